// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge: turns sram-like instruction fetch reads into single-beat AXI reads,
// returning data in request order with up to MAX_OUT reads in flight.
module inst_sram_axi_rd_bridge #(
   parameter int ID_W    = 4,
   parameter int MAX_OUT = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            inst_sram_req,
   input  logic            inst_sram_wr,
   input  logic [1:0]      inst_sram_size,
   input  logic [31:0]     inst_sram_addr,
   input  logic [3:0]      inst_sram_wstrb,
   input  logic [31:0]     inst_sram_wdata,
   output logic            inst_sram_addr_ok,
   output logic            inst_sram_data_ok,
   output logic [31:0]     inst_sram_rdata,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic [1:0]      arlock,
   output logic [3:0]      arcache,
   output logic [2:0]      arprot,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] axi_arid,
   output logic            bus_err
);
   typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
   localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);
   ar_state_t ar_state, ar_next;
   logic [1:0] out_cnt, size_r;
   logic id_tgl, data_ok_r, r_hs, err;
   logic [31:0] rdata_r;
   logic unused_ok;
   assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid};
   assign arvalid = (ar_state == AR_SEND);
   assign rready = (out_cnt != 2'd0);
   assign r_hs = rvalid & rready;
   assign arsize = {1'b0, size_r};
   assign arlen = 8'd0;
   assign arburst = 2'b01;
   assign arlock = 2'b00;
   assign arcache = 4'd0;
   assign arprot = 3'd0;
   assign inst_sram_data_ok = data_ok_r;
   assign inst_sram_rdata = rdata_r;
   // stray beats, write requests and bad responses all latch the sticky error
   assign err = (inst_sram_req & inst_sram_wr) | (rvalid & ~rready)
              | (r_hs & ((rresp != 2'b00) | ~rlast));
   always_comb begin
      ar_next = ar_state;
      inst_sram_addr_ok = 1'b0;
      if (ar_state == AR_IDLE) begin
         inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & (out_cnt < MAX_CNT) & resetn;
         ar_next = inst_sram_addr_ok ? AR_SEND : AR_IDLE;
      end else begin
         ar_next = arready ? AR_IDLE : AR_SEND;
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) ar_state <= AR_IDLE;
      else ar_state <= ar_next;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         araddr <= 32'd0;
         size_r <= 2'd0;
         arid <= '0;
         id_tgl <= 1'b0;
         axi_arid <= '0;
         out_cnt <= 2'd0;
         data_ok_r <= 1'b0;
         rdata_r <= 32'd0;
         bus_err <= 1'b0;
      end else begin
         if (inst_sram_addr_ok) begin
            araddr <= inst_sram_addr;
            size_r <= inst_sram_size;
            arid <= {{(ID_W-1){1'b0}}, id_tgl};
            id_tgl <= ~id_tgl;
         end
         if (arvalid && arready) axi_arid <= arid;
         out_cnt <= out_cnt + 2'(inst_sram_addr_ok) - 2'(r_hs);
         data_ok_r <= r_hs;
         if (r_hs) rdata_r <= rdata;
         if (err) bus_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// tb_inst_sram_axi_rd_bridge: directed cycle tables plus hand sequences for stall and reset cases.
module tb_inst_sram_axi_rd_bridge;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic req = 1'b0, wr = 1'b0;
   logic [1:0] size = 2'd2;
   logic [31:0] addr = 32'd0;
   logic [3:0] wstrb = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic addr_ok, data_ok;
   logic [31:0] srdata;
   logic [3:0] arid, rid, axi_arid;
   logic [31:0] araddr, rdat = 32'd0;
   logic [7:0] arlen;
   logic [2:0] arsize, arprot;
   logic [1:0] arburst, arlock, rresp = 2'd0;
   logic [3:0] arcache;
   logic arvalid, arready = 1'b0, rlast = 1'b1, rvalid = 1'b0, rready, bus_err;
   int checks = 0, failures = 0, hs = 0;
   assign rid = 4'd0;
   inst_sram_axi_rd_bridge #(.ID_W(4), .MAX_OUT(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
      .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
      .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(srdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdat), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .axi_arid(axi_arid), .bus_err(bus_err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (resetn && arvalid && arready) hs <= hs + 1;
   typedef struct {
      logic [31:0] rst, req, wr, size, addr, arready, rvalid, rdat, rresp, rlast;
      logic [31:0] aok, arv, araddr, arid, rrdy, dok, rdata, err;
   } vec_t;
   vec_t tbl[$];
   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      req = 0; wr = 0; size = 2'd2; addr = 0; arready = 0; rvalid = 0; rdat = 0; rresp = 0; rlast = 1;
   endtask
   initial begin
      int h0;
      // rst,req,wr,size,addr,arready,rvalid,rdat,rresp,rlast | aok,arv,araddr,arid,rrdy,dok,rdata,err
      tbl.push_back('{1,0,0,2,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,0,2,32'h1c000000,1,0,0,0,1, 1,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,1,32'h1c000000,0,1,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h1c000000,0,1,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'h02800413,0,1, 0,0,32'h1c000000,0,1,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h1c000000,0,0,1,32'h02800413,0});
      tbl.push_back('{1,0,0,2,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,0,2,32'h100,1,0,0,0,1, 1,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,0,2,32'h100,1,0,0,0,1, 0,1,32'h100,0,1,0,0,0});
      tbl.push_back('{0,1,0,2,32'h104,1,0,0,0,1, 1,0,32'h100,0,1,0,0,0});
      tbl.push_back('{0,1,0,2,32'h104,1,0,0,0,1, 0,1,32'h104,1,1,0,0,0});
      tbl.push_back('{0,1,0,2,32'h108,1,0,0,0,1, 0,0,32'h104,1,1,0,0,0});
      tbl.push_back('{0,1,0,2,32'h108,1,1,32'haaaa0001,0,1, 0,0,32'h104,1,1,0,0,0});
      tbl.push_back('{0,1,0,2,32'h108,1,0,0,0,1, 1,0,32'h104,1,1,1,32'haaaa0001,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'haaaa0002,0,1, 0,1,32'h108,0,1,0,32'haaaa0001,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'haaaa0003,0,1, 0,0,32'h108,0,1,1,32'haaaa0002,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h108,0,0,1,32'haaaa0003,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h108,0,0,0,32'haaaa0003,0});
      tbl.push_back('{0,1,0,2,32'h200,1,0,0,0,1, 1,0,32'h108,0,0,0,32'haaaa0003,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,1,32'h200,1,1,0,32'haaaa0003,0});
      tbl.push_back('{0,1,0,2,32'h204,1,1,32'hbbbb0001,0,1, 1,0,32'h200,1,1,0,32'haaaa0003,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,1,32'h204,0,1,1,32'hbbbb0001,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'hbbbb0002,0,1, 0,0,32'h204,0,1,0,32'hbbbb0001,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h204,0,0,1,32'hbbbb0002,0});
      tbl.push_back('{0,1,0,2,32'h300,1,0,0,0,1, 1,0,32'h204,0,0,0,32'hbbbb0002,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,1,32'h300,1,1,0,32'hbbbb0002,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'hcccc0001,2,1, 0,0,32'h300,1,1,0,32'hbbbb0002,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h300,1,0,1,32'hcccc0001,1});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h300,1,0,0,32'hcccc0001,1});
      tbl.push_back('{1,0,0,2,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,1,2,32'h400,1,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,0,0,0,0,0,1});
      tbl.push_back('{1,0,0,2,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'hdddd0001,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,0,0,0,0,0,1});
      tbl.push_back('{1,0,0,2,0,0,0,0,0,1, 0,0,0,0,0,0,0,0});
      tbl.push_back('{0,1,0,2,32'h500,1,0,0,0,1, 1,0,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,1,32'h500,0,1,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,1,32'heeee0001,0,0, 0,0,32'h500,0,1,0,0,0});
      tbl.push_back('{0,0,0,2,0,1,0,0,0,1, 0,0,32'h500,0,0,1,32'heeee0001,1});
      cyc;
      foreach (tbl[i]) begin
         resetn = ~tbl[i].rst[0]; req = tbl[i].req[0]; wr = tbl[i].wr[0]; size = tbl[i].size[1:0];
         addr = tbl[i].addr; arready = tbl[i].arready[0]; rvalid = tbl[i].rvalid[0];
         rdat = tbl[i].rdat; rresp = tbl[i].rresp[1:0]; rlast = tbl[i].rlast[0];
         #1;
         if (tbl[i].rst == 0) begin
            chk("addr_ok", i, 32'(addr_ok), tbl[i].aok);
            chk("arvalid", i, 32'(arvalid), tbl[i].arv);
            chk("araddr", i, araddr, tbl[i].araddr);
            chk("arid", i, 32'(arid), tbl[i].arid);
            chk("rready", i, 32'(rready), tbl[i].rrdy);
            chk("data_ok", i, 32'(data_ok), tbl[i].dok);
            chk("rdata", i, srdata, tbl[i].rdata);
            chk("bus_err", i, 32'(bus_err), tbl[i].err);
         end
         cyc;
      end
      // AR backpressure: fields frozen while arready is low
      idle_in; resetn = 0; cyc; resetn = 1;
      req = 1; addr = 32'h400; size = 2'd1;
      #1 chk("bp_accept", 0, 32'(addr_ok), 1);
      cyc;
      h0 = hs;
      addr = 32'h500; size = 2'd2;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_arvalid", k, 32'(arvalid), 1);
         chk("bp_araddr", k, araddr, 32'h400);
         chk("bp_arid", k, 32'(arid), 0);
         chk("bp_arsize", k, 32'(arsize), 1);
         chk("bp_addr_ok", k, 32'(addr_ok), 0);
         cyc;
      end
      arready = 1; req = 0;
      #1 chk("bp_last_arvalid", 0, 32'(arvalid), 1);
      cyc;
      chk("bp_arvalid_drop", 0, 32'(arvalid), 0);
      chk("bp_handshakes", 0, 32'(hs - h0), 1);
      chk("bp_const", 0, {arlen, 3'b0, arburst, arlock, arcache, arprot, 8'd0}, {8'd0, 3'b0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0});
      // reset mid-flight with two reads outstanding and an AR pending
      idle_in; resetn = 0; cyc; resetn = 1;
      req = 1; wr = 1; cyc;
      wr = 0; addr = 32'h600; arready = 1; cyc;
      req = 0; cyc;
      rvalid = 1; rdat = 32'h11110001; cyc;
      rvalid = 0; req = 1; addr = 32'h604; cyc;
      req = 0; cyc;
      req = 1; addr = 32'h608; arready = 0; cyc;
      req = 0;
      #1;
      chk("mf_arvalid", 0, 32'(arvalid), 1);
      chk("mf_axi_arid", 0, 32'(axi_arid), 1);
      chk("mf_rready", 0, 32'(rready), 1);
      chk("mf_bus_err", 0, 32'(bus_err), 1);
      resetn = 0; req = 1; rvalid = 1; rdat = 32'hffff0000;
      #1 chk("rst_addr_ok", 0, 32'(addr_ok), 0);
      cyc;
      resetn = 1; req = 0; rvalid = 0;
      #1;
      chk("rst_arvalid", 0, 32'(arvalid), 0);
      chk("rst_rready", 0, 32'(rready), 0);
      chk("rst_data_ok", 0, 32'(data_ok), 0);
      chk("rst_axi_arid", 0, 32'(axi_arid), 0);
      chk("rst_bus_err", 0, 32'(bus_err), 0);
      chk("rst_araddr", 0, araddr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
